// File: rtl/mem_test_pkg.sv
// mem_test_pkg: shared definitions for the march-test sequencer.
//   - default mode fields for write and read command words
//   - bit positions of the command / readback word fields
//   - sequencer state encoding
//   - make_cmd(): packs a command word from its fields
package mem_test_pkg;

  localparam logic [6:0] CMD_WR_MODE = 7'h02;
  localparam logic [6:0] CMD_RD_MODE = 7'h03;

  // Command word: {invert_bit, mode[6:0], addr[15:0], data[7:0]}.
  // Readback word reuses the same layout with the top byte required to be 0.
  localparam int CMD_INV_BIT = 31;
  localparam int CMD_MODE_HI = 30;
  localparam int CMD_MODE_LO = 24;
  localparam int CMD_ADDR_HI = 23;
  localparam int CMD_ADDR_LO = 8;
  localparam int CMD_DATA_HI = 7;
  localparam int CMD_DATA_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [31:0] make_cmd(input logic        inv,
                                           input logic [6:0]  mode,
                                           input logic [15:0] addr,
                                           input logic [7:0]  data);
    logic [31:0] cmd;
    cmd = '0;
    cmd[CMD_INV_BIT]             = inv;
    cmd[CMD_MODE_HI:CMD_MODE_LO] = mode;
    cmd[CMD_ADDR_HI:CMD_ADDR_LO] = addr;
    cmd[CMD_DATA_HI:CMD_DATA_LO] = data;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_march_seq_if.sv
// mem_march_seq_if: command and readback bus between the march sequencer
// and the memory interface adapter.
//   dut_data/dut_valid : command words toward the adapter
//   rb_tdata/rb_tvalid/rb_tready : AXI-Stream readback from the adapter
// master = sequencer side, slave = adapter side.
interface mem_march_seq_if;

  logic [31:0] dut_data;
  logic        dut_valid;
  logic [31:0] rb_tdata;
  logic        rb_tvalid;
  logic        rb_tready;

  modport master (
    output dut_data,
    output dut_valid,
    output rb_tready,
    input  rb_tdata,
    input  rb_tvalid
  );

  modport slave (
    input  dut_data,
    input  dut_valid,
    input  rb_tready,
    output rb_tdata,
    output rb_tvalid
  );

endinterface

// File: rtl/rdback_checker.sv
// rdback_checker: in-order comparison of readback beats against the
// expected march pattern.
//   clk, rst        : clock, synchronous active-high reset
//   load, load_addr : restart checking at load_addr, clear error state
//   pattern, invert : data seed and inversion of the current run
//   beat, beat_data : one readback word to check this cycle
//   err_cnt         : saturating mismatch count
//   first_err_addr/first_err_data : fields of the first mismatching beat
module rdback_checker
  import mem_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic [7:0]  pattern,
  input  logic        invert,
  input  logic        beat,
  input  logic [31:0] beat_data,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_addr,
  output logic [7:0]  first_err_data
);

  logic [15:0] exp_addr_reg, exp_addr_next;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic [15:0] first_err_addr_reg, first_err_addr_next;
  logic [7:0]  first_err_data_reg, first_err_data_next;
  logic [7:0]  exp_data;
  logic        mismatch;

  // Expected data per bit: seed ^ low address byte, flipped when inverting.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_exp_data
      assign exp_data[gi] = pattern[gi] ^ exp_addr_reg[gi] ^ invert;
    end
  endgenerate

  assign mismatch = (beat_data[CMD_INV_BIT:CMD_MODE_LO] != 8'h00) ||
                    (beat_data[CMD_ADDR_HI:CMD_ADDR_LO] != exp_addr_reg) ||
                    (beat_data[CMD_DATA_HI:CMD_DATA_LO] != exp_data);

  always_comb begin
    exp_addr_next       = exp_addr_reg;
    err_cnt_next        = err_cnt_reg;
    first_err_addr_next = first_err_addr_reg;
    first_err_data_next = first_err_data_reg;
    if (load) begin
      exp_addr_next       = load_addr;
      err_cnt_next        = '0;
      first_err_addr_next = '0;
      first_err_data_next = '0;
    end else if (beat) begin
      exp_addr_next = exp_addr_reg + 16'd1;
      if (mismatch) begin
        if (err_cnt_reg != 16'hFFFF) begin
          err_cnt_next = err_cnt_reg + 16'd1;
        end
        // A zero count means nothing has been captured yet in this run.
        if (err_cnt_reg == 16'h0000) begin
          first_err_addr_next = beat_data[CMD_ADDR_HI:CMD_ADDR_LO];
          first_err_data_next = beat_data[CMD_DATA_HI:CMD_DATA_LO];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_reg       <= '0;
      err_cnt_reg        <= '0;
      first_err_addr_reg <= '0;
      first_err_data_reg <= '0;
    end else begin
      exp_addr_reg       <= exp_addr_next;
      err_cnt_reg        <= err_cnt_next;
      first_err_addr_reg <= first_err_addr_next;
      first_err_data_reg <= first_err_data_next;
    end
  end

  assign err_cnt        = err_cnt_reg;
  assign first_err_addr = first_err_addr_reg;
  assign first_err_data = first_err_data_reg;

endmodule

// File: rtl/mem_march_seq.sv
// mem_march_seq: march-test command sequencer with readback checking.
// A run writes pattern ^ addr over [addr_first, addr_last], then reads the
// same window back with at most MAX_OUTSTANDING reads in flight, then drains
// the remaining readback (aborting after TIMEOUT idle cycles).
//   core_clk, rst : clock, synchronous active-high reset
//   start         : launch pulse, honoured in IDLE and DONE
//   addr_first/addr_last/pattern/invert : run configuration, latched on start
//   bus           : command output and readback input (master side)
//   busy, done, timeout, cfg_err : run status
//   err_cnt, first_err_addr, first_err_data : checker results
module mem_march_seq
  import mem_test_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TIMEOUT         = 1024,
  parameter logic [6:0]  WR_MODE         = CMD_WR_MODE,
  parameter logic [6:0]  RD_MODE         = CMD_RD_MODE
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           addr_first,
  input  logic [15:0]           addr_last,
  input  logic [7:0]            pattern,
  input  logic                  invert,
  mem_march_seq_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  cfg_err,
  output logic [15:0]           err_cnt,
  output logic [15:0]           first_err_addr,
  output logic [7:0]            first_err_data
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  // 17 bits so that a window ending at 16'hFFFF compares without wrapping.
  logic [16:0]   addr_reg, addr_next;
  logic [15:0]   first_reg, first_next;
  logic [15:0]   last_reg, last_next;
  logic [7:0]    pattern_reg, pattern_next;
  logic          invert_reg, invert_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic [31:0]   cmd_data_reg, cmd_data_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          timeout_reg, timeout_next;
  logic          cfg_err_reg, cfg_err_next;

  logic          accept;
  logic          issue;
  logic          beat;
  logic          beat_live;
  logic          dec;
  logic          last_addr;

  assign bus.rb_tready = 1'b1;
  assign beat          = bus.rb_tvalid & bus.rb_tready;
  // Only beats that belong to the read pass reach the checker.
  assign beat_live     = beat && (state_reg == ST_READ || state_reg == ST_DRAIN);
  assign accept        = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign last_addr     = (addr_reg == {1'b0, last_reg});
  // Guard against underflow from stray beats beyond what was issued.
  assign dec           = beat_live && (outstanding_reg != '0);

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    first_next       = first_reg;
    last_next        = last_reg;
    pattern_next     = pattern_reg;
    invert_next      = invert_reg;
    outstanding_next = outstanding_reg;
    timeout_next     = timeout_reg;
    cfg_err_next     = cfg_err_reg;
    cmd_valid_next   = 1'b0;
    cmd_data_next    = '0;
    issue            = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          first_next       = addr_first;
          last_next        = addr_last;
          pattern_next     = pattern;
          invert_next      = invert;
          addr_next        = {1'b0, addr_first};
          outstanding_next = '0;
          timeout_next     = 1'b0;
          if (addr_last < addr_first) begin
            cfg_err_next = 1'b1;
            state_next   = ST_DONE;
          end else begin
            cfg_err_next = 1'b0;
            state_next   = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        cmd_valid_next = 1'b1;
        cmd_data_next  = make_cmd(1'b0, WR_MODE, addr_reg[15:0],
                                  pattern_reg ^ addr_reg[7:0]);
        if (last_addr) begin
          addr_next  = {1'b0, first_reg};
          state_next = ST_READ;
        end else begin
          addr_next = addr_reg + 17'd1;
        end
      end

      ST_READ: begin
        if (outstanding_reg < OW'(MAX_OUTSTANDING)) begin
          issue          = 1'b1;
          cmd_valid_next = 1'b1;
          cmd_data_next  = make_cmd(invert_reg, RD_MODE, addr_reg[15:0], 8'h00);
          if (last_addr) begin
            state_next = ST_DRAIN;
          end else begin
            addr_next = addr_reg + 17'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (outstanding_reg == '0) begin
          state_next = ST_DONE;
        end else if (!beat && idle_reg == IW'(TIMEOUT - 1)) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Issue and return in the same cycle cancel out.
    if (issue && !dec) begin
      outstanding_next = outstanding_reg + OW'(1);
    end else if (!issue && dec) begin
      outstanding_next = outstanding_reg - OW'(1);
    end

    if (state_reg == ST_DRAIN && !beat) begin
      idle_next = idle_reg + IW'(1);
    end else begin
      idle_next = '0;
    end

    // Registered one state behind so busy and done swap on the same edge.
    busy_next = (state_reg == ST_WRITE || state_reg == ST_READ ||
                 state_reg == ST_DRAIN) && (state_next != ST_DONE);
    done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      first_reg       <= '0;
      last_reg        <= '0;
      pattern_reg     <= '0;
      invert_reg      <= 1'b0;
      outstanding_reg <= '0;
      idle_reg        <= '0;
      cmd_data_reg    <= '0;
      cmd_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      cfg_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      pattern_reg     <= pattern_next;
      invert_reg      <= invert_next;
      outstanding_reg <= outstanding_next;
      idle_reg        <= idle_next;
      cmd_data_reg    <= cmd_data_next;
      cmd_valid_reg   <= cmd_valid_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      timeout_reg     <= timeout_next;
      cfg_err_reg     <= cfg_err_next;
    end
  end

  rdback_checker u_checker (
    .clk            (core_clk),
    .rst            (rst),
    .load           (accept),
    .load_addr      (addr_first),
    .pattern        (pattern_reg),
    .invert         (invert_reg),
    .beat           (beat_live),
    .beat_data      (bus.rb_tdata),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  assign bus.dut_data  = cmd_data_reg;
  assign bus.dut_valid = cmd_valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign timeout       = timeout_reg;
  assign cfg_err       = cfg_err_reg;

endmodule

// File: tb/tb_mem_march_seq.sv
// tb_mem_march_seq: directed bench for mem_march_seq with a loopback
// adapter model (memory array, configurable latency, inversion, corruption
// and beat dropping) and a scoreboard of expected command words.
module tb_mem_march_seq;

  logic        core_clk = 1'b0;
  logic        rst      = 1'b1;
  logic        start    = 1'b0;
  logic [15:0] addr_first = '0;
  logic [15:0] addr_last  = '0;
  logic [7:0]  pattern    = '0;
  logic        invert     = 1'b0;
  logic        busy, done, timeout, cfg_err;
  logic [15:0] err_cnt, first_err_addr;
  logic [7:0]  first_err_data;

  mem_march_seq_if bus_if ();

  mem_march_seq dut (
    .core_clk       (core_clk),
    .rst            (rst),
    .start          (start),
    .addr_first     (addr_first),
    .addr_last      (addr_last),
    .pattern        (pattern),
    .invert         (invert),
    .bus            (bus_if),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .cfg_err        (cfg_err),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 core_clk = ~core_clk;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- adapter model + scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    logic        inv;
    int          due;
  } rd_t;

  logic [31:0] sb[$];
  rd_t         pend[$];
  logic [7:0]  mem [0:65535];

  int          lat = 4;
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = '0;
  logic        drop_en = 1'b0;
  logic [15:0] drop_addr = '0;
  logic        stray_req = 1'b0;

  int cyc = 0;
  int cmd_cnt = 0;
  int beat_cnt = 0;
  int model_out = 0;
  int max_out = 0;
  int last_beat_cyc = 0;
  int done_rise_cyc = 0;

  initial begin
    bus_if.rb_tvalid = 1'b0;
    bus_if.rb_tdata  = '0;
  end

  always @(negedge core_clk) begin : model
    rd_t         r;
    logic [31:0] w;
    logic [7:0]  d;
    logic        done_q;
    logic        stray_q;
    cyc++;
    if (done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
    done_q = done;
    if (rst) begin
      pend.delete();
      model_out        = 0;
      bus_if.rb_tvalid = 1'b0;
      bus_if.rb_tdata  = '0;
    end else begin
      if (bus_if.dut_valid === 1'b1) begin
        cmd_cnt++;
        w = bus_if.dut_data;
        check32("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check32("cmd_word", w, sb.pop_front());
        if (w[30:24] == 7'h02) begin
          mem[w[23:8]] = w[7:0];
        end else begin
          r.addr = w[23:8];
          r.inv  = w[31];
          r.due  = cyc + lat;
          pend.push_back(r);
          model_out++;
          if (model_out > max_out) max_out = model_out;
        end
      end
      bus_if.rb_tvalid = 1'b0;
      bus_if.rb_tdata  = '0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        model_out--;
        if (!(drop_en && r.addr == drop_addr)) begin
          d = r.inv ? ~mem[r.addr] : mem[r.addr];
          if (corrupt_en && r.addr == corrupt_addr) d = 8'h00;
          bus_if.rb_tvalid = 1'b1;
          bus_if.rb_tdata  = {8'h00, r.addr, d};
          beat_cnt++;
          last_beat_cyc = cyc;
        end
      end else if (stray_req && !stray_q) begin
        bus_if.rb_tvalid = 1'b1;
        bus_if.rb_tdata  = 32'hFF1234_00;
      end
      stray_q = stray_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge core_clk);
    start = 1'b1;
    @(negedge core_clk);
    start = 1'b0;
  endtask

  task automatic do_run(input logic [15:0] f, input logic [15:0] l,
                        input logic [7:0] p, input logic inv);
    addr_first = f;
    addr_last  = l;
    pattern    = p;
    invert     = inv;
    for (int a = int'(f); a <= int'(l); a++) sb.push_back({1'b0, 7'h02, a[15:0], p ^ a[7:0]});
    for (int a = int'(f); a <= int'(l); a++) sb.push_back({inv, 7'h03, a[15:0], 8'h00});
    pulse_start();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin
      @(negedge core_clk);
      i++;
    end
    check32({tag, "_done"}, 32'(done), 32'd1);
    repeat (3) @(negedge core_clk);
    @(posedge core_clk);
    #1;
  endtask

  task automatic settle();
    @(posedge core_clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int b0, c0;

  initial begin
    // Reset values
    repeat (3) @(negedge core_clk);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_timeout", 32'(timeout), 32'd0);
    check32("rst_cfg_err", 32'(cfg_err), 32'd0);
    check32("rst_err_cnt", 32'(err_cnt), 32'd0);
    check32("rst_first_addr", 32'(first_err_addr), 32'd0);
    check32("rst_first_data", 32'(first_err_data), 32'd0);
    check32("rst_dut_valid", 32'(bus_if.dut_valid), 32'd0);
    check32("rst_dut_data", bus_if.dut_data, 32'd0);
    check32("rst_tready", 32'(bus_if.rb_tready), 32'd1);
    rst = 1'b0;
    settle();

    // Basic window, launch latency
    b0 = beat_cnt;
    do_run(16'h0010, 16'h0013, 8'hA5, 1'b0);
    check32("t1_busy_n", 32'(busy), 32'd0);
    check32("t1_valid_n", 32'(bus_if.dut_valid), 32'd0);
    @(negedge core_clk);
    check32("t1_busy_n1", 32'(busy), 32'd1);
    check32("t1_valid_n1", 32'(bus_if.dut_valid), 32'd1);
    check32("t1_first_word", bus_if.dut_data, 32'h020010B5);
    wait_done(500, "t1");
    check32("t1_busy_end", 32'(busy), 32'd0);
    check32("t1_err_cnt", 32'(err_cnt), 32'd0);
    check32("t1_timeout", 32'(timeout), 32'd0);
    check32("t1_beats", 32'(beat_cnt - b0), 32'd4);
    check32("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Stray beat while in DONE is discarded
    @(negedge core_clk);
    stray_req = 1'b1;
    repeat (3) @(negedge core_clk);
    stray_req = 1'b0;
    check32("stray_err_cnt", 32'(err_cnt), 32'd0);
    check32("stray_first_addr", 32'(first_err_addr), 32'd0);
    settle();

    // Inverted readback
    b0 = beat_cnt;
    do_run(16'h0010, 16'h0013, 8'hA5, 1'b1);
    wait_done(500, "inv");
    check32("inv_err_cnt", 32'(err_cnt), 32'd0);
    check32("inv_beats", 32'(beat_cnt - b0), 32'd4);
    check32("inv_sb_empty", 32'(sb.size()), 32'd0);

    // Single corrupted location
    corrupt_en   = 1'b1;
    corrupt_addr = 16'h0012;
    do_run(16'h0010, 16'h0013, 8'hA5, 1'b0);
    wait_done(500, "cor");
    check32("cor_err_cnt", 32'(err_cnt), 32'd1);
    check32("cor_first_addr", 32'(first_err_addr), 32'h0012);
    check32("cor_first_data", 32'(first_err_data), 32'h00);
    corrupt_en = 1'b0;

    // Long latency, outstanding limit
    lat     = 40;
    max_out = 0;
    b0      = beat_cnt;
    do_run(16'h0100, 16'h013F, 8'h3C, 1'b0);
    wait_done(3000, "lat40");
    check32("lat40_err_cnt", 32'(err_cnt), 32'd0);
    check32("lat40_beats", 32'(beat_cnt - b0), 32'd64);
    check32("lat40_max_out", 32'(max_out), 32'd8);
    check32("lat40_sb_empty", 32'(sb.size()), 32'd0);
    lat = 4;

    // Top-of-range window, no wrap
    c0 = cmd_cnt;
    b0 = beat_cnt;
    do_run(16'hFFFE, 16'hFFFF, 8'h5A, 1'b0);
    wait_done(500, "top");
    repeat (20) @(negedge core_clk);
    settle();
    check32("top_cmds", 32'(cmd_cnt - c0), 32'd4);
    check32("top_beats", 32'(beat_cnt - b0), 32'd2);
    check32("top_err_cnt", 32'(err_cnt), 32'd0);
    check32("top_sb_empty", 32'(sb.size()), 32'd0);

    // Dropped final beat, DRAIN timeout
    drop_en   = 1'b1;
    drop_addr = 16'h0023;
    b0        = beat_cnt;
    do_run(16'h0020, 16'h0023, 8'h11, 1'b0);
    wait_done(2000, "tmo");
    check32("tmo_timeout", 32'(timeout), 32'd1);
    check32("tmo_busy", 32'(busy), 32'd0);
    check32("tmo_err_cnt", 32'(err_cnt), 32'd0);
    check32("tmo_beats", 32'(beat_cnt - b0), 32'd3);
    check32("tmo_idle_span", 32'(done_rise_cyc - last_beat_cyc), 32'd1025);
    drop_en = 1'b0;

    // Inverted window -> cfg_err, no commands
    c0 = cmd_cnt;
    do_run(16'h0005, 16'h0004, 8'h00, 1'b0);
    repeat (20) @(negedge core_clk);
    settle();
    check32("cfg_cfg_err", 32'(cfg_err), 32'd1);
    check32("cfg_done", 32'(done), 32'd1);
    check32("cfg_timeout_clr", 32'(timeout), 32'd0);
    check32("cfg_busy", 32'(busy), 32'd0);
    check32("cfg_cmds", 32'(cmd_cnt - c0), 32'd0);

    // Reset in the middle of a run
    do_run(16'h0030, 16'h003F, 8'h77, 1'b0);
    repeat (24) @(negedge core_clk);
    rst = 1'b1;
    settle();
    sb.delete();
    @(negedge core_clk);
    check32("mrst_busy", 32'(busy), 32'd0);
    check32("mrst_done", 32'(done), 32'd0);
    check32("mrst_valid", 32'(bus_if.dut_valid), 32'd0);
    check32("mrst_data", bus_if.dut_data, 32'd0);
    check32("mrst_cfg_err", 32'(cfg_err), 32'd0);
    check32("mrst_tready", 32'(bus_if.rb_tready), 32'd1);
    @(negedge core_clk);
    rst = 1'b0;
    settle();

    // Recovery run after reset
    b0 = beat_cnt;
    do_run(16'h0040, 16'h0047, 8'hC3, 1'b0);
    wait_done(500, "rec");
    check32("rec_err_cnt", 32'(err_cnt), 32'd0);
    check32("rec_beats", 32'(beat_cnt - b0), 32'd8);
    check32("rec_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
